medidor_frecuencia: RTL and testbench

Gate-time frequency meter: counts rising edges of an asynchronous square-wave input over a fixed window of `clk` cycles and reports the result in Hz. It is the receive-side counterpart of the tone divider. It closes the loop on the music box: generated tones are measured back for self-test, and external tones are measured for tuning. Its `freq` output uses the same signed 32-bit Hz format as the divider's `freq` input, so a measurement can be fed straight back into the divider.

---
 rtl/musica_defs.sv | 14 +
 rtl/medidor_frecuencia_if.sv | 17 +
 rtl/sincronizador_flanco.sv | 29 ++
 rtl/medidor_frecuencia.sv | 92 +++++++++
 tb/tb_medidor_frecuencia.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/musica_defs.sv
// musica_defs: constants and FSM encodings shared by the music-box tone blocks.
`default_nettype none

package musica_defs;
  localparam int unsigned FPGA_CLK_HZ = 50_000_000;
  localparam int          FREQ_W      = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MEDIR = 1'b1
  } estado_t;
endpackage

`default_nettype wire

// File: rtl/medidor_frecuencia_if.sv
// medidor_frecuencia_if: control, input signal and measurement result of the meter.
`default_nettype none

interface medidor_frecuencia_if;
  import musica_defs::*;

  logic                     en;
  logic                     sig_in;
  logic signed [FREQ_W-1:0] freq;
  logic                     freq_valid;
  logic                     busy;

  modport master (output en, output sig_in, input freq, input freq_valid, input busy);
  modport slave  (input en, input sig_in, output freq, output freq_valid, output busy);
endinterface

`default_nettype wire

// File: rtl/sincronizador_flanco.sv
// sincronizador_flanco: 2-FF synchronizer plus rising-edge detector (also usable for buttons).
`default_nettype none

module sincronizador_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
endmodule

`default_nettype wire

// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: gate-time frequency meter, counts sig_in rising edges per window and reports Hz.
`default_nettype none

module medidor_frecuencia
  import musica_defs::*;
#(
  parameter int unsigned CLK_HZ      = FPGA_CLK_HZ,
  parameter int unsigned GATE_CYCLES = FPGA_CLK_HZ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  medidor_frecuencia_if.slave  mf
);
  localparam int unsigned SCALE  = CLK_HZ / GATE_CYCLES;
  localparam int          GATE_W = $clog2(GATE_CYCLES);
  localparam int          EDGE_W = $clog2(GATE_CYCLES / 2 + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  estado_t                  estado;
  logic [GATE_W-1:0]        gate_cnt;
  logic [EDGE_W-1:0]        edge_cnt;
  logic signed [FREQ_W-1:0] freq_r;
  logic                     freq_valid_r;
  logic                     busy_r;
  logic                     rise;
  logic [EDGE_W:0]          edge_total;
  logic [FREQ_W-1:0]        freq_next;

  sincronizador_flanco u_sinc (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mf.sig_in),
    .rise  (rise)
  );

  // An edge seen on the closing cycle still belongs to the closing window.
  assign edge_total = {1'b0, edge_cnt} + (EDGE_W + 1)'(rise);
  assign freq_next  = FREQ_W'(edge_total) * FREQ_W'(SCALE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= IDLE;
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      freq_r       <= '0;
      freq_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      freq_valid_r <= 1'b0;
      case (estado)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          if (mf.en) begin
            estado <= MEDIR;
            busy_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        MEDIR: begin
          if (gate_cnt == GATE_LAST) begin
            freq_r       <= $signed(freq_next);
            freq_valid_r <= 1'b1;
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            if (!mf.en) begin
              estado <= IDLE;
              busy_r <= 1'b0;
            end
          end else if (!mf.en) begin
            // Partial window is dropped; freq keeps the last completed result.
            estado   <= IDLE;
            busy_r   <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= edge_cnt + EDGE_W'(rise);
          end
        end
      endcase
    end
  end

  assign mf.freq       = freq_r;
  assign mf.freq_valid = freq_valid_r;
  assign mf.busy       = busy_r;
endmodule

`default_nettype wire

// File: tb/tb_medidor_frecuencia.sv
// tb_medidor_frecuencia: randomized scoreboard bench with a window-level reference model.
`default_nettype none

module tb_medidor_frecuencia;
  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned GATE   = 100;
  localparam int unsigned SCALE  = CLK_HZ / GATE;

  typedef struct {
    int f;
    int c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  medidor_frecuencia_if bus ();

  medidor_frecuencia #(.CLK_HZ(CLK_HZ), .GATE_CYCLES(GATE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mf    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: a sig_in level sampled at edge k shows up as a counted rise two
  // edges later; a window opened at edge s counts rises at edges s+1..s+GATE.
  logic hist[$];
  exp_t exp_q[$];
  int   cyc = 0;
  bit   open = 0;
  int   age, cnt;
  bit   m_busy = 0;
  int   m_freq = 0;

  function automatic logic h(int i);
    if (hist.size() > i) return hist[hist.size() - 1 - i];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic r;
    cyc++;
    if (!rst_n) begin
      hist.delete();
      exp_q.delete();
      open   = 0;
      m_busy = 0;
      m_freq = 0;
    end else begin
      hist.push_back(bus.sig_in);
      if (hist.size() > 4) void'(hist.pop_front());
      r = h(2) & ~h(3);
      if (!open) begin
        if (bus.en) begin
          open = 1; age = 0; cnt = 0;
        end
      end else begin
        age++;
        cnt += int'(r);
        if (age == GATE) begin
          m_freq = cnt * SCALE;
          exp_q.push_back('{f: m_freq, c: cyc});
          if (bus.en) begin age = 0; cnt = 0; end
          else open = 0;
        end else if (!bus.en) begin
          open = 0;
        end
      end
      m_busy = open;
    end
  end

  // Monitor: every strobe must match the next expected result, on the expected cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      bit   pend;
      exp_t e;
      pend = (exp_q.size() != 0);
      if (bus.freq_valid || pend) begin
        chk("freq_valid", longint'(bus.freq_valid), longint'(pend));
        if (pend) begin
          e = exp_q.pop_front();
          if (bus.freq_valid) begin
            chk("freq_at_strobe", bus.freq, e.f);
            chk("strobe_cycle", cyc, e.c);
          end
        end
      end
      chk("busy", longint'(bus.busy), longint'(m_busy));
      chk("freq_level", bus.freq, m_freq);
    end
  end

  task automatic step(input logic e, input logic s);
    @(negedge clk);
    bus.en     = e;
    bus.sig_in = s;
  endtask

  // mode 0: period-10 square wave, 1: toggle every clock, 2: constant high
  task automatic run_wave(input int mode, input int idle_len, input int en_len);
    int  p;
    logic s;
    p = 0;
    for (int i = 0; i < idle_len + en_len; i++) begin
      case (mode)
        0:       s = ((p % 10) < 5);
        1:       s = p[0];
        default: s = 1'b1;
      endcase
      p++;
      step(i >= idle_len, s);
    end
  endtask

  function automatic logic dir_sig(int j);
    return (j >= 98 && j < 150) || (j >= 199);
  endfunction

  initial begin
    int strobes;
    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_freq", bus.freq, 0);
    chk("reset_valid", longint'(bus.freq_valid), 0);
    chk("reset_busy", longint'(bus.busy), 0);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 1'b0);

    // Edge on the closing cycle, edge on the first cycle of a window, en drop, re-enable.
    for (int j = 0; j < 556; j++) begin
      step(!(j >= 351 && j < 450), dir_sig(j));
      if (j == 0)   chk("busy_before_start", longint'(bus.busy), 0);
      if (j == 1)   chk("busy_after_start", longint'(bus.busy), 1);
      if (j == 101) begin
        chk("close_edge_valid", longint'(bus.freq_valid), 1);
        chk("close_edge_freq", bus.freq, 10);
      end
      if (j == 201) chk("quiet_window_freq", bus.freq, 0);
      if (j == 301) chk("first_cycle_edge_freq", bus.freq, 10);
      if (j == 351) chk("busy_before_drop", longint'(bus.busy), 1);
      if (j == 352) begin
        chk("busy_after_drop", longint'(bus.busy), 0);
        chk("freq_held_after_drop", bus.freq, 10);
      end
      if (j == 550) chk("reenable_not_early", longint'(bus.freq_valid), 0);
      if (j == 551) begin
        chk("reenable_full_window", longint'(bus.freq_valid), 1);
        chk("reenable_freq", bus.freq, 0);
      end
    end

    run_wave(0, 30, 350);
    chk("period10_freq", bus.freq, 100);
    run_wave(1, 30, 350);
    chk("toggle_freq", bus.freq, 500);

    strobes = 0;
    for (int i = 0; i < 30 + 350; i++) begin
      step(i >= 30, 1'b1);
      if (bus.freq_valid) strobes++;
    end
    chk("constant_freq", bus.freq, 0);
    chk("constant_strobes", strobes, 3);

    // Async reset at gate_cnt=70 with freq=100.
    run_wave(0, 30, 272);
    chk("pre_reset_freq", bus.freq, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_freq", bus.freq, 0);
    chk("async_reset_busy", longint'(bus.busy), 0);
    chk("async_reset_valid", longint'(bus.freq_valid), 0);
    repeat (3) step(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);

    // Random segments: random toggle density and occasional en drops.
    for (int seg = 0; seg < 20; seg++) begin
      int   len, dens, drop;
      logic s;
      len  = $urandom_range(400, 150);
      dens = $urandom_range(8, 1);
      drop = $urandom_range(400, 60);
      s    = bus.sig_in;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(dens - 1, 0) == 0) s = ~s;
        step(($urandom_range(drop - 1, 0) != 0), s);
      end
    end

    repeat (5) step(1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
